// File: rtl/borrow_select_subtractor_seq_if.sv
// Operand/result bus for the sequential borrow-select subtractor.
// The slave side is the subtractor; the master side is whoever feeds it.
interface borrow_select_subtractor_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output in_valid, A, B, bin, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );

    modport slave (
        input  in_valid, A, B, bin, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
endinterface

// File: rtl/borrow_select_subtractor_seq.sv
// Multi-cycle subtractor computing A - B - bin one CHUNK-bit slice per clock,
// LSB first; each slice is formed for both borrow-in values and the running borrow picks one.
module borrow_select_subtractor_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input logic                           clk,
    input logic                           rst_n,
    borrow_select_subtractor_seq_if.slave bus
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("borrow_select_subtractor_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             runBorrow_q, runBorrow_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] sliceA;
    logic [CHUNK-1:0] sliceB;
    logic [CHUNK:0]   diffNoBorrow;
    logic [CHUNK:0]   diffWithBorrow;
    logic [CHUNK:0]   sliceSel;
    logic             inReady;
    logic             outValid;

    // Both borrow-in candidates for the current slice; the top bit of each is its borrow-out.
    always_comb begin
        sliceA = '0;
        sliceB = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx_q == IDXW'(k)) begin
                sliceA = opA_q[k*CHUNK +: CHUNK];
                sliceB = opB_q[k*CHUNK +: CHUNK];
            end
        end
        diffNoBorrow   = {1'b0, sliceA} - {1'b0, sliceB};
        diffWithBorrow = diffNoBorrow - (CHUNK+1)'(1);
        sliceSel       = runBorrow_q ? diffWithBorrow : diffNoBorrow;
    end

    always_comb begin
        state_d     = state_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        runBorrow_d = runBorrow_q;
        idx_d       = idx_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        inReady     = 1'b0;
        outValid    = 1'b0;

        case (state_q)
            IDLE: begin
                inReady = 1'b1;
                if (bus.in_valid) begin
                    opA_d       = bus.A;
                    opB_d       = bus.B;
                    runBorrow_d = bus.bin;
                    idx_d       = '0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                for (int k = 0; k < NCH; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        diff_d[k*CHUNK +: CHUNK] = sliceSel[CHUNK-1:0];
                    end
                end
                runBorrow_d = sliceSel[CHUNK];
                idx_d       = idx_q + IDXW'(1);
                // The last slice holds the sign bit, so overflow is resolved here.
                if (idx_q == LAST_IDX) begin
                    borrow_d = sliceSel[CHUNK];
                    ovf_d    = (opA_q[WIDTH-1] != opB_q[WIDTH-1]) &&
                               (diff_d[WIDTH-1] != opA_q[WIDTH-1]);
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                outValid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            runBorrow_q <= 1'b0;
            idx_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            runBorrow_q <= runBorrow_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// Directed and random checks of the sequential borrow-select subtractor (WIDTH=8, CHUNK=4).
module tb_borrow_select_subtractor_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;

    borrow_select_subtractor_seq_if #(.WIDTH(8)) bus ();

    borrow_select_subtractor_seq #(
        .WIDTH(8),
        .CHUNK(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {ovf, borrow, diff} from a plain 9-bit subtraction.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] full;
        logic       ov;
        full = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        ov   = (a[7] != b[7]) && (full[7] != a[7]);
        return {ov, full[8], full[7:0]};
    endfunction

    // Drives one operation and completes the output handshake; lat=-1 if it never finished.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output logic [7:0] d, output logic br, output logic ov, output int lat);
        int waitCnt;
        waitCnt = 0;
        lat = -1;
        d   = '0;
        br  = 1'b0;
        ov  = 1'b0;
        while (bus.in_ready !== 1'b1 && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        bus.A        = a;
        bus.B        = b;
        bus.bin      = bi;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat > 0) begin
            d  = bus.diff;
            br = bus.borrow;
            ov = bus.ovf;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        nChecks++; if (bus.diff !== 8'h00) begin nFails++; $display("[TB] FAIL reset_diff: got %h expected 00", bus.diff); end
        nChecks++; if (bus.borrow !== 1'b0) begin nFails++; $display("[TB] FAIL reset_borrow: got %b expected 0", bus.borrow); end
        nChecks++; if (bus.ovf !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic       br, ov;
        int         lat;
        do_op(8'h53, 8'h35, 1'b0, d, br, ov, lat);
        nChecks++; if (lat !== 2) begin nFails++; $display("[TB] FAIL basic_latency: got %0d expected 2", lat); end
        nChecks++; if ({ov, br, d} !== {1'b0, 1'b0, 8'h1E}) begin nFails++; $display("[TB] FAIL basic_result: got ovf=%b borrow=%b diff=%h expected ovf=0 borrow=0 diff=1e", ov, br, d); end
    endtask

    task automatic test_borrow_ripple();
        logic [7:0] d;
        logic       br, ov;
        int         lat;
        do_op(8'h00, 8'h01, 1'b0, d, br, ov, lat);
        nChecks++; if ({ov, br, d} !== {1'b0, 1'b1, 8'hFF}) begin nFails++; $display("[TB] FAIL ripple_result: got ovf=%b borrow=%b diff=%h expected ovf=0 borrow=1 diff=ff", ov, br, d); end
        do_op(8'h5A, 8'h5A, 1'b1, d, br, ov, lat);
        nChecks++; if ({ov, br, d} !== {1'b0, 1'b1, 8'hFF}) begin nFails++; $display("[TB] FAIL equal_bin_result: got ovf=%b borrow=%b diff=%h expected ovf=0 borrow=1 diff=ff", ov, br, d); end
    endtask

    task automatic test_absorb();
        logic [7:0] d;
        logic       br, ov;
        int         lat;
        do_op(8'h10, 8'h0F, 1'b1, d, br, ov, lat);
        nChecks++; if ({ov, br, d} !== {1'b0, 1'b0, 8'h00}) begin nFails++; $display("[TB] FAIL absorb_result: got ovf=%b borrow=%b diff=%h expected ovf=0 borrow=0 diff=00", ov, br, d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       br, ov;
        int         lat;
        do_op(8'h80, 8'h01, 1'b0, d, br, ov, lat);
        nChecks++; if ({ov, br, d} !== {1'b1, 1'b0, 8'h7F}) begin nFails++; $display("[TB] FAIL ovf_neg_result: got ovf=%b borrow=%b diff=%h expected ovf=1 borrow=0 diff=7f", ov, br, d); end
        do_op(8'h7F, 8'hFF, 1'b0, d, br, ov, lat);
        nChecks++; if ({ov, br, d} !== {1'b1, 1'b1, 8'h80}) begin nFails++; $display("[TB] FAIL ovf_pos_result: got ovf=%b borrow=%b diff=%h expected ovf=1 borrow=1 diff=80", ov, br, d); end
    endtask

    task automatic test_backpressure();
        int seen;
        bus.A        = 8'h53;
        bus.B        = 8'h35;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1;
        end
        nChecks++; if (seen !== 1) begin nFails++; $display("[TB] FAIL bp_first_done: got %0d expected 1", seen); end
        bus.A        = 8'h22;
        bus.B        = 8'h33;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nChecks++; if (bus.out_valid !== 1'b1) begin nFails++; $display("[TB] FAIL bp_hold_valid: got %b expected 1", bus.out_valid); end
            nChecks++; if (bus.diff !== 8'h1E) begin nFails++; $display("[TB] FAIL bp_hold_diff: got %h expected 1e", bus.diff); end
            nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        nChecks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin nFails++; $display("[TB] FAIL bp_release: got in_ready,out_valid=%b expected 10", {bus.in_ready, bus.out_valid}); end
        tick();
        bus.in_valid = 1'b0;
        nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL bp_second_accept: got in_ready=%b expected 0", bus.in_ready); end
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1;
        end
        nChecks++; if ({seen[0], bus.ovf, bus.borrow, bus.diff} !== {1'b1, 1'b0, 1'b1, 8'hEF}) begin nFails++; $display("[TB] FAIL bp_second_result: got done=%0d ovf=%b borrow=%b diff=%h expected done=1 ovf=0 borrow=1 diff=ef", seen, bus.ovf, bus.borrow, bus.diff); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
        nChecks++; if ({bus.out_valid, bus.borrow, bus.diff} !== {1'b0, 1'b1, 8'hEF}) begin nFails++; $display("[TB] FAIL hold_after_handshake: got out_valid=%b borrow=%b diff=%h expected out_valid=0 borrow=1 diff=ef", bus.out_valid, bus.borrow, bus.diff); end
    endtask

    task automatic test_reset_calc();
        int staleSeen;
        bus.A        = 8'h00;
        bus.B        = 8'h01;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL rcalc_busy: got in_ready=%b expected 0", bus.in_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rcalc_in_ready: got %b expected 1", bus.in_ready); end
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rcalc_out_valid: got %b expected 0", bus.out_valid); end
        nChecks++; if (bus.diff !== 8'h00) begin nFails++; $display("[TB] FAIL rcalc_diff: got %h expected 00", bus.diff); end
        staleSeen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) staleSeen++;
        end
        nChecks++; if (staleSeen !== 0) begin nFails++; $display("[TB] FAIL rcalc_no_stale: got %0d valid cycles expected 0", staleSeen); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, d;
        logic       bi, br, ov;
        logic [9:0] exp;
        int         lat;
        for (int n = 0; n < 10000; n++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            bi  = 1'($urandom);
            exp = model(a, b, bi);
            do_op(a, b, bi, d, br, ov, lat);
            nChecks++; if (lat !== 2) begin nFails++; $display("[TB] FAIL rand_latency: A=%h B=%h bin=%b got %0d expected 2", a, b, bi, lat); end
            nChecks++; if ({ov, br, d} !== exp) begin nFails++; $display("[TB] FAIL rand_result: A=%h B=%h bin=%b got %h expected %h", a, b, bi, {ov, br, d}, exp); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_borrow_ripple();
        test_absorb();
        test_overflow();
        test_backpressure();
        test_reset_calc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
